// File: rtl/branch_predictor_pkg.sv
// Shared constants and helpers for the dynamic branch predictor and the
// pipeline registers that carry the prediction down to EX.
package branch_predictor_pkg;

  localparam int PC_W    = 32;
  localparam int TGT_LSB = 2;
  localparam int TGT_W   = PC_W - TGT_LSB;

  // One operation per cycle on a saturating counter; LOAD wins by construction.
  typedef enum logic [1:0] {
    CTR_HOLD = 2'd0,
    CTR_INC  = 2'd1,
    CTR_DEC  = 2'd2,
    CTR_LOAD = 2'd3
  } ctr_op_e;

  // Freshly allocated entries start weakly taken: only the MSB set.
  function automatic int unsigned ctr_weak_taken(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with parallel load; used for the per-entry
// direction counters and for both statistics counters.
module sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  ctr_op_e          op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case (op)
        CTR_INC:  if (count != '1) count <= count + WIDTH'(1);
        CTR_DEC:  if (count != '0) count <= count - WIDTH'(1);
        CTR_LOAD: count <= load_val;
        default:  count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters: predicts
// at fetch, trains and detects mispredictions on branches resolved in EX.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bp_en,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [PC_W-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] WEAK_TAKEN = CTR_W'(ctr_weak_taken(CTR_W));

  logic             valid   [ENTRIES];
  logic [TAG_W-1:0] tags    [ENTRIES];
  logic [TGT_W-1:0] targets [ENTRIES];
  logic [CTR_W-1:0] ctrs    [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             unused_pc_bits;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], if_pc >> (IDX_W + TAG_W + 2)};

  // Lookup reads the stored entry directly, so a same-cycle update is not seen.
  assign if_hit      = valid[if_idx] && (tags[if_idx] == if_tag);
  assign pred_taken  = bp_en && !reset && if_hit && ctrs[if_idx][CTR_W-1];
  assign pred_target = pred_taken ? {targets[if_idx], 2'b00} : '0;

  assign upd_hit = valid[upd_idx] && (tags[upd_idx] == upd_tag);

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (upd_valid) begin
      mispredict  = (upd_taken != upd_pred_taken) ||
                    (upd_taken && (upd_target != upd_pred_target));
      redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);
    end
  end

  // Taken branches either refresh the target of a hit or evict whatever lives at the index.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) valid[i] <= 1'b0;
    end else if (upd_valid && upd_taken) begin
      valid[upd_idx]   <= 1'b1;
      tags[upd_idx]    <= upd_tag;
      targets[upd_idx] <= upd_target[PC_W-1:TGT_LSB];
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    ctr_op_e op;

    always_comb begin
      op = CTR_HOLD;
      if (upd_valid && (upd_idx == IDX_W'(i))) begin
        if (upd_hit)        op = upd_taken ? CTR_INC : CTR_DEC;
        else if (upd_taken) op = CTR_LOAD;
      end
    end

    sat_counter #(.WIDTH(CTR_W)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .op       (op),
      .load_val (WEAK_TAKEN),
      .count    (ctrs[i])
    );
  end

  ctr_op_e branch_op;
  ctr_op_e mispred_op;

  assign branch_op  = upd_valid  ? CTR_INC : CTR_HOLD;
  assign mispred_op = mispredict ? CTR_INC : CTR_HOLD;

  sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
    .clk      (clk),
    .reset    (reset),
    .op       (branch_op),
    .load_val ('0),
    .count    (branch_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mispred_cnt (
    .clk      (clk),
    .reset    (reset),
    .op       (mispred_op),
    .load_val ('0),
    .count    (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a random
// run, all compared against a table-level behavioural model of the BTB.
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int TAG_W   = 8;
  localparam int CTR_W   = 2;
  localparam int CNT_W   = 2;
  localparam int CTR_MAX = (1 << CTR_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        bp_en;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model state
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int          m_branch;
  int          m_mispred;

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .bp_en(bp_en), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, input logic en, input logic rst,
                                   output logic t, output logic [31:0] tgt);
    int i;
    bit hit;
    i   = m_idx(pc);
    hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
    t   = en && !rst && hit && (m_ctr[i] >= (1 << (CTR_W - 1)));
    tgt = t ? m_target[i] : 32'd0;
  endfunction

  function automatic void m_train(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    int i;
    bit hit;
    i   = m_idx(pc);
    hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
    if (hit) begin
      if (t) begin
        m_ctr[i]    = (m_ctr[i] < CTR_MAX) ? m_ctr[i] + 1 : CTR_MAX;
        m_target[i] = tgt & ~32'd3;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (t) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = m_tagof(pc);
      m_target[i] = tgt & ~32'd3;
      m_ctr[i]    = 1 << (CTR_W - 1);
    end
  endfunction

  function automatic bit m_mispredict();
    if (!upd_valid) return 1'b0;
    return (upd_taken != upd_pred_taken) || (upd_taken && (upd_target != upd_pred_target));
  endfunction

  function automatic logic [31:0] m_redirect();
    if (!upd_valid) return 32'd0;
    return upd_taken ? upd_target : upd_pc + 32'd4;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_branch  = 0;
    m_mispred = 0;
  endfunction

  // Advance one clock, mirroring the edge in the model, and settle 1 unit after it.
  task automatic tick();
    bit mp;
    @(posedge clk);
    mp = m_mispredict();
    if (reset) begin
      m_reset();
    end else if (upd_valid) begin
      m_train(upd_pc, upd_taken, upd_target);
      m_branch = (m_branch < CNT_MAX) ? m_branch + 1 : CNT_MAX;
      if (mp) m_mispred = (m_mispred < CNT_MAX) ? m_mispred + 1 : CNT_MAX;
    end
    #1;
  endtask

  task automatic drive_upd(input logic v, input logic [31:0] pc, input logic t,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    upd_valid = v; upd_pc = pc; upd_taken = t; upd_target = tgt;
    upd_pred_taken = pt; upd_pred_target = ptgt;
  endtask

  // The prediction a branch carries is whatever the predictor said for its PC at fetch.
  task automatic drive_upd_model(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    logic pt;
    logic [31:0] ptgt;
    m_lookup(pc, bp_en, reset, pt, ptgt);
    drive_upd(1'b1, pc, t, tgt, pt, ptgt);
  endtask

  task automatic idle_upd();
    drive_upd(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    bp_en = 1'b1; reset = 1'b1; if_pc = 32'h00400010;
    drive_upd(1'b1, 32'h00400010, 1'b1, 32'h00400040, 1'b0, 32'd0);
    #1;
    total_cnt++; if (mispredict !== 1'b1) $display("[TB] FAIL reset_cycle_mispredict: got %b expected 1", mispredict); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 32'h00400040) $display("[TB] FAIL reset_cycle_redirect: got %h expected 00400040", redirect_pc); else pass_cnt++;
    tick();
    reset = 1'b0; idle_upd();
    #1;
    total_cnt++; if (pred_taken !== 1'b0) $display("[TB] FAIL reset_pred_taken: got %b expected 0", pred_taken); else pass_cnt++;
    total_cnt++; if (pred_target !== 32'd0) $display("[TB] FAIL reset_pred_target: got %h expected 0", pred_target); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 2'd0) $display("[TB] FAIL reset_branch_cnt: got %0d expected 0", branch_cnt); else pass_cnt++;
    total_cnt++; if (mispred_cnt !== 2'd0) $display("[TB] FAIL reset_mispred_cnt: got %0d expected 0", mispred_cnt); else pass_cnt++;
  endtask

  task automatic test_cold_taken();
    if_pc = 32'h00400010;
    drive_upd(1'b1, 32'h00400010, 1'b1, 32'h00400040, 1'b0, 32'd0);
    #1;
    total_cnt++; if (mispredict !== 1'b1) $display("[TB] FAIL cold_mispredict: got %b expected 1", mispredict); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 32'h00400040) $display("[TB] FAIL cold_redirect: got %h expected 00400040", redirect_pc); else pass_cnt++;
    total_cnt++; if (pred_taken !== 1'b0) $display("[TB] FAIL cold_pre_lookup: got %b expected 0", pred_taken); else pass_cnt++;
    tick();
    idle_upd();
    #1;
    total_cnt++; if (pred_taken !== 1'b1) $display("[TB] FAIL cold_relookup_taken: got %b expected 1", pred_taken); else pass_cnt++;
    total_cnt++; if (pred_target !== 32'h00400040) $display("[TB] FAIL cold_relookup_target: got %h expected 00400040", pred_target); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 2'd1) $display("[TB] FAIL cold_branch_cnt: got %0d expected 1", branch_cnt); else pass_cnt++;
  endtask

  task automatic test_counter_training();
    logic exp_mp [3];
    exp_mp[0] = 1'b1; exp_mp[1] = 1'b0; exp_mp[2] = 1'b0;
    if_pc = 32'h00400010;
    for (int k = 0; k < 3; k++) begin
      drive_upd_model(32'h00400010, 1'b0, 32'h00400040);
      #1;
      total_cnt++; if (mispredict !== exp_mp[k]) $display("[TB] FAIL train_nt%0d_mispredict: got %b expected %b", k, mispredict, exp_mp[k]); else pass_cnt++;
      total_cnt++; if (redirect_pc !== 32'h00400014) $display("[TB] FAIL train_nt%0d_redirect: got %h expected 00400014", k, redirect_pc); else pass_cnt++;
      tick();
      idle_upd();
      #1;
      total_cnt++; if (pred_taken !== 1'b0) $display("[TB] FAIL train_nt%0d_pred: got %b expected 0", k, pred_taken); else pass_cnt++;
    end
    total_cnt++; if (mispred_cnt !== 2'd2) $display("[TB] FAIL train_mispred_cnt: got %0d expected 2", mispred_cnt); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 2'd3) $display("[TB] FAIL train_branch_cnt_sat: got %0d expected 3", branch_cnt); else pass_cnt++;
  endtask

  task automatic test_aliasing();
    for (int k = 0; k < 2; k++) begin
      drive_upd_model(32'h00400010, 1'b1, 32'h00400040);
      tick();
    end
    idle_upd();
    if_pc = 32'h00400010; #1;
    total_cnt++; if (pred_taken !== 1'b1) $display("[TB] FAIL alias_owner_pred: got %b expected 1", pred_taken); else pass_cnt++;
    if_pc = 32'h00400110; #1;
    total_cnt++; if (pred_taken !== 1'b0) $display("[TB] FAIL alias_other_miss: got %b expected 0", pred_taken); else pass_cnt++;
    drive_upd_model(32'h00400110, 1'b1, 32'h00400200);
    tick();
    idle_upd();
    if_pc = 32'h00400010; #1;
    total_cnt++; if (pred_taken !== 1'b0) $display("[TB] FAIL alias_evicted: got %b expected 0", pred_taken); else pass_cnt++;
    if_pc = 32'h00400110; #1;
    total_cnt++; if (pred_target !== 32'h00400200) $display("[TB] FAIL alias_new_target: got %h expected 00400200", pred_target); else pass_cnt++;
  endtask

  task automatic test_bp_disable();
    reset = 1'b1; idle_upd(); tick(); reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_upd_model(32'h00400110, 1'b1, 32'h00400200);
      tick();
    end
    idle_upd();
    bp_en = 1'b0; if_pc = 32'h00400110; #1;
    total_cnt++; if (pred_taken !== 1'b0) $display("[TB] FAIL bp_off_pred: got %b expected 0", pred_taken); else pass_cnt++;
    total_cnt++; if (pred_target !== 32'd0) $display("[TB] FAIL bp_off_target: got %h expected 0", pred_target); else pass_cnt++;
    drive_upd_model(32'h00400110, 1'b1, 32'h00400200);
    #1;
    total_cnt++; if (mispredict !== 1'b1) $display("[TB] FAIL bp_off_mispredict: got %b expected 1", mispredict); else pass_cnt++;
    tick();
    idle_upd();
    #1;
    total_cnt++; if (mispred_cnt !== 2'd2) $display("[TB] FAIL bp_off_mispred_cnt: got %0d expected 2", mispred_cnt); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 2'd3) $display("[TB] FAIL bp_off_branch_cnt: got %0d expected 3", branch_cnt); else pass_cnt++;
    bp_en = 1'b1;
  endtask

  task automatic test_same_cycle();
    if_pc = 32'h00400110;
    drive_upd_model(32'h00400110, 1'b1, 32'h00400300);
    #1;
    total_cnt++; if (pred_target !== 32'h00400200) $display("[TB] FAIL same_cycle_old_target: got %h expected 00400200", pred_target); else pass_cnt++;
    total_cnt++; if (mispredict !== 1'b1) $display("[TB] FAIL same_cycle_target_mispredict: got %b expected 1", mispredict); else pass_cnt++;
    tick();
    idle_upd();
    #1;
    total_cnt++; if (pred_target !== 32'h00400300) $display("[TB] FAIL same_cycle_new_target: got %h expected 00400300", pred_target); else pass_cnt++;
    if_pc = 32'h00400020;
    drive_upd(1'b1, 32'h00400020, 1'b1, 32'h00400080, 1'b0, 32'd0);
    #1;
    total_cnt++; if (pred_taken !== 1'b0) $display("[TB] FAIL same_cycle_alloc_old: got %b expected 0", pred_taken); else pass_cnt++;
    tick();
    idle_upd();
    #1;
    total_cnt++; if (pred_target !== 32'h00400080) $display("[TB] FAIL same_cycle_alloc_new: got %h expected 00400080", pred_target); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic outcome [4];
    logic exp_pred [5];
    logic mt;
    logic [31:0] mtgt;
    outcome[0] = 1'b0; outcome[1] = 1'b0; outcome[2] = 1'b1; outcome[3] = 1'b1;
    exp_pred[0] = 1'b1; exp_pred[1] = 1'b0; exp_pred[2] = 1'b0; exp_pred[3] = 1'b0; exp_pred[4] = 1'b1;
    if_pc = 32'h00400020;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive_upd_model(32'h00400020, outcome[k], 32'h00400080);
      else idle_upd();
      #1;
      m_lookup(if_pc, bp_en, reset, mt, mtgt);
      total_cnt++; if (pred_taken !== exp_pred[k] || pred_taken !== mt) $display("[TB] FAIL b2b_pred%0d: got %b expected %b", k, pred_taken, exp_pred[k]); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_saturation();
    reset = 1'b1; idle_upd(); tick(); reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_upd(1'b1, 32'h00400030, 1'b1, 32'h00400400, 1'b0, 32'd0);
      #1;
      total_cnt++; if (mispredict !== 1'b1) $display("[TB] FAIL sat_mispredict%0d: got %b expected 1", k, mispredict); else pass_cnt++;
      tick();
    end
    idle_upd();
    #1;
    total_cnt++; if (branch_cnt !== 2'd3) $display("[TB] FAIL sat_branch_cnt: got %0d expected 3", branch_cnt); else pass_cnt++;
    total_cnt++; if (mispred_cnt !== 2'd3) $display("[TB] FAIL sat_mispred_cnt: got %0d expected 3", mispred_cnt); else pass_cnt++;
  endtask

  task automatic test_random();
    logic mt;
    logic [31:0] mtgt;
    logic [31:0] pc;
    reset = 1'b1; idle_upd(); tick(); reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      bp_en = ($urandom_range(0, 7) != 0);
      if_pc = 32'h00400000 | (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 1)) << 8)
              | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        pc = 32'h00400000 | (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 1)) << 8);
        drive_upd_model(pc, 1'($urandom_range(0, 1)), 32'h00400000 + 32'($urandom_range(0, 255)) * 4);
        if ($urandom_range(0, 7) == 0) upd_pred_target = upd_pred_target ^ 32'd4;
        if ($urandom_range(0, 15) == 0) upd_pred_taken = ~upd_pred_taken;
      end else begin
        idle_upd();
      end
      #1;
      m_lookup(if_pc, bp_en, reset, mt, mtgt);
      total_cnt++; if (pred_taken !== mt) $display("[TB] FAIL rnd%0d_pred_taken: got %b expected %b", n, pred_taken, mt); else pass_cnt++;
      total_cnt++; if (pred_target !== mtgt) $display("[TB] FAIL rnd%0d_pred_target: got %h expected %h", n, pred_target, mtgt); else pass_cnt++;
      total_cnt++; if (mispredict !== m_mispredict()) $display("[TB] FAIL rnd%0d_mispredict: got %b expected %b", n, mispredict, m_mispredict()); else pass_cnt++;
      total_cnt++; if (redirect_pc !== m_redirect()) $display("[TB] FAIL rnd%0d_redirect: got %h expected %h", n, redirect_pc, m_redirect()); else pass_cnt++;
      total_cnt++; if (branch_cnt !== CNT_W'(m_branch)) $display("[TB] FAIL rnd%0d_branch_cnt: got %0d expected %0d", n, branch_cnt, m_branch); else pass_cnt++;
      total_cnt++; if (mispred_cnt !== CNT_W'(m_mispred)) $display("[TB] FAIL rnd%0d_mispred_cnt: got %0d expected %0d", n, mispred_cnt, m_mispred); else pass_cnt++;
      tick();
    end
    reset = 1'b0; idle_upd();
  endtask

  initial begin
    reset = 1'b0; bp_en = 1'b1; if_pc = 32'd0;
    idle_upd();
    m_reset();
    @(negedge clk);
    test_reset();
    test_cold_taken();
    test_counter_training();
    test_aliasing();
    test_bp_disable();
    test_same_cycle();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the five-stage pipeline. It is the successor to EX-stage static not-taken resolution.
- **IF side:** a direct-mapped branch target buffer (BTB) with per-entry saturating counters predicts direction and target for the fetch PC in the same cycle.
- **EX side:** it trains on resolved conditional branches and flags mispredictions with the correct redirect PC.
- **Statistics:** saturating branch and mispredict counters are exposed for the DataMem-mapped LED/BCD display.

## Interface
Parameters:
- ENTRIES, 64, BTB/counter entries; power of two, ≥ 2; IDX_W = log2(ENTRIES)
- TAG_W, 8, tag bits stored per entry; IDX_W + TAG_W ≤ 30
- CTR_W, 2, direction counter width, ≥ 1
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- bp_en  in  1  1 = dynamic prediction; 0 = force static not-taken (tables still train)
- if_pc  in  32  fetch PC
- pred_taken  out  1  predicted taken for if_pc
- pred_target  out  32  predicted target; 0 when pred_taken = 0
- upd_valid  in  1  EX holds a resolved conditional branch this cycle
- upd_pc  in  32  PC of that branch
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual taken target (PC+4 + imm<<2)
- upd_pred_taken  in  1  prediction carried down the pipe with the branch
- upd_pred_target  in  32  predicted target carried with the branch
- mispredict  out  1  flush IF/ID and ID/EX, redirect PC
- redirect_pc  out  32  correct next PC when mispredict = 1
- branch_cnt  out  CNT_W  resolved branches, saturating
- mispred_cnt  out  CNT_W  mispredictions, saturating

## Operation
- **Address split:**
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - pc[1:0] is ignored.
- **Entry contents:** valid, tag, target[31:2], ctr[CTR_W-1:0].
- **Lookup (combinational):**
  - hit = valid[idx] && tag match.
  - pred_taken = bp_en && hit && ctr[MSB].
  - pred_target = {target, 2'b00} when pred_taken, else 0.
- **Mispredict (combinational, gated by upd_valid):**
  - mispredict = upd_taken ≠ upd_pred_taken, OR (upd_taken && upd_target ≠ upd_pred_target).
  - redirect_pc = upd_taken ? upd_target : upd_pc + 4.
  - Both outputs are 0 when upd_valid = 0.
- **Training (registered, on upd_valid):**
  - *Hit:* ctr saturating +1 if taken, −1 if not taken. On taken, target is rewritten with upd_target.
  - *Miss, taken:* allocate the entry, overwriting any previous occupant. Set valid = 1, tag, target, and ctr = 2^(CTR_W−1) (weakly taken).
  - *Miss, not taken:* no change.
  - *Counter limits:* ctr saturates at 0 and at 2^CTR_W−1. With CTR_W = 1 the counter reduces to a last-outcome bit.
- **Statistics:**
  - branch_cnt += 1 per upd_valid.
  - mispred_cnt += 1 per mispredict.
  - Both stick at 2^CNT_W−1.
- **bp_en = 0:** pred_taken = 0, so every taken branch mispredicts. This reproduces the legacy static behaviour. Training and statistics continue unchanged.

## Timing
- **Reset:**
  - Registered state: all valid = 0, branch_cnt = mispred_cnt = 0. Target and tag arrays are not reset.
  - Outputs in the reset cycle: pred_taken = 0, pred_target = 0; mispredict and redirect_pc follow their inputs combinationally.
  - Reset mid-training discards that cycle's update.
- **Latencies:**
  - Lookup: zero cycles, same cycle as if_pc.
  - mispredict/redirect_pc: zero cycles from the upd_* inputs.
  - Training: visible to lookups from the cycle after the update edge.
- **Same-index lookup and update in one cycle:** the lookup returns the pre-update entry; there is no bypass.
- **Update during reset:** reset wins.
- **Back-to-back updates to one index:** each applies in order, one per cycle.
- **Pipeline contract:** the pipeline gates upd_valid off for flushed or bubble instructions. The predictor performs no stall or flush gating itself.

## Structure
- **Shared package:** PC width (32), the counter-init/saturate helper, and the entry field layout are shared constants/functions, used by this block and the pipeline registers that carry upd_pred_*.
- **Sub-module:** one, sat_counter (parametrised width, inc/dec/load, saturating). It is instantiated per entry and for both statistics counters.
- **Storage:** arrays are flop-based.

## Test plan
- **Reset, then lookup:** assert reset 1 cycle, then lookup if_pc = 0x00400010 → pred_taken = 0, pred_target = 0, branch_cnt = 0.
- **Cold taken branch, then relookup:** upd_valid with upd_pc = 0x00400010, taken, target 0x00400040, pred 0 → mispredict = 1, redirect_pc = 0x00400040. Next cycle, if_pc = 0x00400010 → pred_taken = 1, pred_target = 0x00400040.
- **Counter training (CTR_W = 2):** two not-taken updates on the allocated entry → ctr 2→1→0, pred_taken = 0. Third not-taken → ctr stays 0, mispredict = 0 (pred 0, actual 0), redirect_pc = 0x00400014.
- **Aliasing (ENTRIES = 64, TAG_W = 8):** PC 0x00400010 and 0x00400110 share an index; lookup of 0x00400110 after training 0x00400010 → miss, pred_taken = 0. A taken update at 0x00400110 evicts 0x00400010.
- **bp_en = 0:** trained taken entry, bp_en = 0 → pred_taken = 0. Update taken → mispredict = 1 and mispred_cnt increments.
- **Same-cycle hazard and saturation (CNT_W = 2):**
  - Lookup and update of the same index in one cycle → the old entry is returned.
  - 5 mispredicting updates → branch_cnt = mispred_cnt = 3.
